hex_display_scan: RTL

- Downstream consumer of the 8-bit LED counter value: shows it as two hex digits on a 2-digit multiplexed, common-anode 7-segment display.
- Time-multiplexes the two digits and applies 3-bit PWM brightness with built-in anti-ghosting dead time.
- Loads the displayed value only at frame boundaries, so a digit never shows a mix of old and new values (no tearing).
- Sits between the counter's 8-bit output and the board segment/anode pins.

---
 rtl/display_pkg.sv | 38 +++
 rtl/hex7seg_decode.sv | 18 +
 rtl/hex_display_scan.sv | 127 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_pkg: shared constants, hex font and timing helper for the    |
// | multiplexed hex display.                                              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package display_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [1:0] AN_OFF  = 2'b11;

  typedef enum logic {
    DIGIT_LO = 1'b0,
    DIGIT_HI = 1'b1
  } digit_e;

  // Active-low {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Cycles per digit slot; 0 flags a configuration that cannot be split
  // into eight equal PWM sub-slots.
  function automatic int unsigned slot_cycles(input int unsigned clk_freq,
                                              input int unsigned frame_hz);
    int unsigned slots;
    slots = clk_freq / (2 * frame_hz);
    if ((slots < 8) || ((slots % 8) != 0)) begin
      slots = 0;
    end
    return slots;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex7seg_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex7seg_decode: 4-bit nibble to active-low 7-segment pattern.        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module hex7seg_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_FONT[nibble];
  end

endmodule
`default_nettype wire

// File: rtl/hex_display_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_display_scan: two-digit multiplexed hex display driver with PWM  |
// | brightness, dead-time sub-slot and tear-free frame loading.           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module hex_display_scan
  import display_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned FRAME_HZ = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  input  logic [2:0] bright,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int unsigned SLOT_CYCLES = slot_cycles(CLK_FREQ, FRAME_HZ);
  localparam int unsigned SUB_CYCLES  = SLOT_CYCLES / 8;
  localparam int unsigned SLOT_W      = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned SUB_W       = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;

  if (SLOT_CYCLES == 0) begin : g_bad_config
    $error("hex_display_scan: CLK_FREQ/(2*FRAME_HZ) must be >= 8 and a multiple of 8");
  end

  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [SUB_W-1:0]  sub_cnt_q, sub_cnt_d;
  logic [2:0]        sub_idx_q, sub_idx_d;
  digit_e            digit_q, digit_d;
  logic [7:0]        shadow_value_q, shadow_value_d;
  logic [2:0]        shadow_bright_q, shadow_bright_d;
  logic              shadow_blank_q, shadow_blank_d;
  logic              frame_tick_q, frame_tick_d;
  logic [1:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic              slot_wrap;
  logic              sub_wrap;
  logic              frame_edge;
  logic              digit_lit;
  logic [3:0]        nibble;
  logic [6:0]        font_seg;

  hex7seg_decode u_decode (
    .nibble (nibble),
    .seg    (font_seg)
  );

  always_comb begin
    slot_wrap  = (slot_cnt_q == SLOT_W'(SLOT_CYCLES - 1));
    sub_wrap   = (sub_cnt_q == SUB_W'(SUB_CYCLES - 1));
    frame_edge = slot_wrap && (digit_q == DIGIT_HI);

    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + SLOT_W'(1);
    sub_cnt_d  = sub_wrap ? '0 : sub_cnt_q + SUB_W'(1);
    // Eight sub-slots tile a slot exactly, so this stays slot-aligned.
    sub_idx_d  = sub_wrap ? sub_idx_q + 3'd1 : sub_idx_q;

    digit_d = digit_q;
    if (frame_edge) begin
      digit_d = DIGIT_LO;
    end else if (slot_wrap) begin
      digit_d = DIGIT_HI;
    end

    shadow_value_d  = shadow_value_q;
    shadow_bright_d = shadow_bright_q;
    shadow_blank_d  = shadow_blank_q;
    frame_tick_d    = frame_edge;
    if (frame_edge) begin
      shadow_value_d  = value;
      shadow_bright_d = bright;
      shadow_blank_d  = blank_lz;
    end

    nibble    = (digit_q == DIGIT_HI) ? shadow_value_q[7:4] : shadow_value_q[3:0];
    // Sub-slot 7 can never satisfy the compare, giving the dead time.
    digit_lit = (sub_idx_q < shadow_bright_q) &&
                !((digit_q == DIGIT_HI) && shadow_blank_q &&
                  (shadow_value_q[7:4] == 4'd0));

    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (digit_lit) begin
      an_d  = (digit_q == DIGIT_HI) ? 2'b01 : 2'b10;
      seg_d = font_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q      <= '0;
      sub_cnt_q       <= '0;
      sub_idx_q       <= 3'd0;
      digit_q         <= DIGIT_LO;
      shadow_value_q  <= 8'd0;
      shadow_bright_q <= 3'd0;
      shadow_blank_q  <= 1'b0;
      frame_tick_q    <= 1'b0;
      an_q            <= AN_OFF;
      seg_q           <= SEG_OFF;
    end else begin
      slot_cnt_q      <= slot_cnt_d;
      sub_cnt_q       <= sub_cnt_d;
      sub_idx_q       <= sub_idx_d;
      digit_q         <= digit_d;
      shadow_value_q  <= shadow_value_d;
      shadow_bright_q <= shadow_bright_d;
      shadow_blank_q  <= shadow_blank_d;
      frame_tick_q    <= frame_tick_d;
      an_q            <= an_d;
      seg_q           <= seg_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
